// File: rtl/data_seq_checker.sv
// data_seq_checker
//   Tracks an incrementing word sequence (0..WRAP-1, wrapping) arriving from
//   a receiver stage. Acquires lock after LOCK_N consecutive in-order words.
//   While locked, every out-of-order word pulses chk_err and is counted.
//   Lock is dropped after ERR_MAX consecutive misses.
//
// Parameters
//   DW      data word width
//   WRAP    sequence length (WRAP <= 2**DW)
//   LOCK_N  consecutive matches needed to lock
//   ERR_MAX consecutive misses in lock before lock is dropped
//
// Ports
//   clk_b    in   clock (single domain)
//   rst_n    in   async active-low reset
//   data_vld in   word valid (back-to-back allowed)
//   data     in   received word [DW]
//   sw_clr   in   sync clear of statistics counters (FSM unaffected)
//   chk_lock out  high while locked
//   chk_err  out  one-cycle pulse per mismatch seen in lock
//   exp_data out  next expected word [DW]
//   err_cnt  out  mismatches seen in lock, saturates at 255
//   rx_cnt   out  accepted word count, wraps (only with DATA_SEQ_CHK_STAT_EN)
//
// Build option
//   DATA_SEQ_CHK_STAT_EN  adds the rx_cnt counter and port.
//
// All outputs come straight from flops: a word sampled on edge N shows its
// effect after edge N.
module data_seq_checker #(
  parameter int DW      = 4,
  parameter int WRAP    = 8,
  parameter int LOCK_N  = 2,
  parameter int ERR_MAX = 3
) (
  input  logic          clk_b,
  input  logic          rst_n,
  input  logic          data_vld,
  input  logic [DW-1:0] data,
  input  logic          sw_clr,
  output logic          chk_lock,
  output logic          chk_err,
  output logic [DW-1:0] exp_data,
  output logic [7:0]    err_cnt
`ifdef DATA_SEQ_CHK_STAT_EN
  ,
  output logic [15:0]   rx_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

  // Counter widths hold the full threshold value.
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int BW = $clog2(ERR_MAX + 1);

  localparam logic [DW-1:0] LAST   = DW'(WRAP - 1);
  localparam logic [DW:0]   WRAP_X = (DW + 1)'(WRAP);

  // Everything the sequencer carries from one word to the next.
  typedef struct packed {
    state_t          st;
    logic [DW-1:0]   exp;
    logic [GW-1:0]   good;
    logic [BW-1:0]   bad;
    logic            err;
  } chk_st_t;

  chk_st_t cur, nxt;

  logic          in_range;
  logic          match;
  logic          lock_miss;
  logic [DW-1:0] anchor;
  logic [DW-1:0] exp_inc;

  function automatic logic [DW-1:0] inc_wrap(input logic [DW-1:0] v);
    return (v == LAST) ? '0 : v + DW'(1);
  endfunction

  // Out-of-range words can never match and re-anchor to 0.
  assign in_range  = {1'b0, data} < WRAP_X;
  assign anchor    = in_range ? inc_wrap(data) : '0;
  assign exp_inc   = inc_wrap(cur.exp);
  assign match     = data_vld && in_range && (data == cur.exp);
  assign lock_miss = data_vld && (cur.st == LOCK) && !match;

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    nxt     = cur;
    nxt.err = 1'b0;
    if (data_vld) begin
      unique case (cur.st)
        IDLE: begin
          nxt.exp  = anchor;
          nxt.good = GW'(1);
          nxt.bad  = '0;
          nxt.st   = (LOCK_N == 1) ? LOCK : SYNC;
        end
        SYNC: begin
          if (match) begin
            nxt.exp = exp_inc;
            // Compare in int so LOCK_N==1 cannot overflow the counter.
            if (int'(cur.good) + 1 >= LOCK_N) begin
              nxt.good = GW'(LOCK_N);
              nxt.bad  = '0;
              nxt.st   = LOCK;
            end else begin
              nxt.good = cur.good + GW'(1);
            end
          end else begin
            // Silent re-acquire: no error reporting before lock.
            nxt.exp  = anchor;
            nxt.good = GW'(1);
          end
        end
        LOCK: begin
          if (match) begin
            nxt.exp = exp_inc;
            nxt.bad = '0;
          end else begin
            nxt.err = 1'b1;
            nxt.exp = anchor;
            if (int'(cur.bad) + 1 >= ERR_MAX) begin
              nxt.st   = SYNC;
              nxt.good = GW'(1);
              nxt.bad  = '0;
            end else begin
              nxt.bad = cur.bad + BW'(1);
            end
          end
        end
        default: nxt.st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) cur <= '{st: IDLE, exp: '0, good: '0, bad: '0, err: 1'b0};
    else        cur <= nxt;
  end

  // ---------------------------------------------------------------------
  // Statistics. sw_clr wins over a same-cycle increment.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n)                          err_cnt <= '0;
    else if (sw_clr)                     err_cnt <= '0;
    else if (lock_miss && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end

`ifdef DATA_SEQ_CHK_STAT_EN
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n)        rx_cnt <= '0;
    else if (sw_clr)   rx_cnt <= '0;
    else if (data_vld) rx_cnt <= rx_cnt + 16'd1;
  end
`endif

  assign chk_lock = (cur.st == LOCK);
  assign chk_err  = cur.err;
  assign exp_data = cur.exp;

endmodule

// File: tb/tb_data_seq_checker.sv
module tb_data_seq_checker;
  localparam int DW      = 4;
  localparam int WRAP    = 8;
  localparam int LOCK_N  = 2;
  localparam int ERR_MAX = 3;

  logic          clk_b    = 1'b0;
  logic          rst_n    = 1'b0;
  logic          data_vld = 1'b0;
  logic [DW-1:0] data     = '0;
  logic          sw_clr   = 1'b0;
  logic          chk_lock, chk_err;
  logic [DW-1:0] exp_data;
  logic [7:0]    err_cnt;
`ifdef DATA_SEQ_CHK_STAT_EN
  logic [15:0]   rx_cnt;
`endif

  always #5 clk_b = ~clk_b;

  data_seq_checker #(.DW(DW), .WRAP(WRAP), .LOCK_N(LOCK_N), .ERR_MAX(ERR_MAX)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .data_vld(data_vld), .data(data), .sw_clr(sw_clr),
    .chk_lock(chk_lock), .chk_err(chk_err), .exp_data(exp_data), .err_cnt(err_cnt)
`ifdef DATA_SEQ_CHK_STAT_EN
    , .rx_cnt(rx_cnt)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- reference model (rule level) ----------------
  // mode: 0 = waiting for first word, 1 = acquiring, 2 = locked
  int m_mode, m_exp, m_run, m_miss, m_ec, m_rx;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_ec = 0; m_rx = 0; m_err = 0;
  endtask

  task automatic model_step(input bit vld, input int d, input bit clr);
    int nxt_anchor;
    bit hit;
    m_err = 0;
    if (clr)      m_rx = 0;
    else if (vld) m_rx = (m_rx + 1) % 65536;
    if (clr) m_ec = 0;
    if (vld) begin
      hit        = (d == m_exp);
      nxt_anchor = (d < WRAP) ? (d + 1) % WRAP : 0;
      if (m_mode == 0) begin
        m_exp = nxt_anchor; m_run = 1; m_miss = 0;
        m_mode = (LOCK_N == 1) ? 2 : 1;
      end else if (m_mode == 1) begin
        if (hit) begin
          m_exp = (m_exp + 1) % WRAP; m_run++;
          if (m_run >= LOCK_N) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_exp = nxt_anchor; m_run = 1;
        end
      end else begin
        if (hit) begin
          m_exp = (m_exp + 1) % WRAP; m_miss = 0;
        end else begin
          m_err = 1;
          if (!clr && m_ec < 255) m_ec++;
          m_exp = nxt_anchor; m_miss++;
          if (m_miss >= ERR_MAX) begin m_mode = 1; m_run = 1; m_miss = 0; end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_lock"}, int'(chk_lock), int'(m_mode == 2));
    chk({tag, "_err"},  int'(chk_err),  int'(m_err));
    chk({tag, "_exp"},  int'(exp_data), m_exp);
    chk({tag, "_ecnt"}, int'(err_cnt),  m_ec);
`ifdef DATA_SEQ_CHK_STAT_EN
    chk({tag, "_rx"},   int'(rx_cnt),   m_rx);
`endif
  endtask

  // Drive one cycle; sample #1 after the edge.
  task automatic step(input bit vld, input int d, input bit clr);
    data_vld = vld; data = d[DW-1:0]; sw_clr = clr;
    @(posedge clk_b);
    #1;
    model_step(vld, d, clr);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit vld; int d; bit clr;
    bit lk; bit er; int ex; int ec;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int d;
    bit v, c;

    tbl[0]  = '{1, 0, 0,  0, 0, 1, 0};   // first word anchors
    tbl[1]  = '{1, 1, 0,  1, 0, 2, 0};   // lock after 2nd word
    tbl[2]  = '{1, 2, 0,  1, 0, 3, 0};
    tbl[3]  = '{0, 5, 0,  1, 0, 3, 0};   // idle cycle holds
    tbl[4]  = '{1, 9, 0,  1, 1, 0, 1};   // out-of-range word
    tbl[5]  = '{1, 0, 0,  1, 0, 1, 1};
    tbl[6]  = '{1, 4, 0,  1, 1, 5, 2};   // miss, re-anchor to 5
    tbl[7]  = '{1, 5, 0,  1, 0, 6, 2};
    tbl[8]  = '{1, 6, 0,  1, 0, 7, 2};
    tbl[9]  = '{1, 7, 0,  1, 0, 0, 2};   // wrap 7 -> 0
    tbl[10] = '{1, 0, 0,  1, 0, 1, 2};
    tbl[11] = '{1, 1, 0,  1, 0, 2, 2};
    tbl[12] = '{1, 5, 0,  1, 1, 6, 3};   // three consecutive misses
    tbl[13] = '{1, 5, 0,  1, 1, 6, 4};
    tbl[14] = '{1, 15, 0, 0, 1, 0, 5};   // lock dropped
    tbl[15] = '{0, 0, 0,  0, 0, 0, 5};   // err was a single pulse
    tbl[16] = '{1, 3, 0,  0, 0, 4, 5};   // miss while acquiring: silent
    tbl[17] = '{1, 4, 0,  1, 0, 5, 5};   // relock
    tbl[18] = '{1, 3, 1,  1, 1, 4, 0};   // sw_clr + miss in lock
    tbl[19] = '{0, 0, 0,  1, 0, 4, 0};

    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("rst_lock", int'(chk_lock), 0);
    chk("rst_err",  int'(chk_err),  0);
    chk("rst_exp",  int'(exp_data), 0);
    chk("rst_ecnt", int'(err_cnt),  0);
`ifdef DATA_SEQ_CHK_STAT_EN
    chk("rst_rx",   int'(rx_cnt),   0);
`endif
    @(posedge clk_b); #1;

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].d, tbl[i].clr);
      chk($sformatf("t%0d_lock", i), int'(chk_lock), int'(tbl[i].lk));
      chk($sformatf("t%0d_err",  i), int'(chk_err),  int'(tbl[i].er));
      chk($sformatf("t%0d_exp",  i), int'(exp_data), tbl[i].ex);
      chk($sformatf("t%0d_ecnt", i), int'(err_cnt),  tbl[i].ec);
`ifdef DATA_SEQ_CHK_STAT_EN
      chk($sformatf("t%0d_rx",   i), int'(rx_cnt),   m_rx);
`endif
    end
`ifdef DATA_SEQ_CHK_STAT_EN
    // rx_cnt cleared by sw_clr on row 18, untouched by the idle row 19.
    chk("clr_rx", int'(rx_cnt), 0);
`endif

    // ---------------- async reset while locked ----------------
    step(1, 7, 0);                        // miss: err pulse, err_cnt=1
    check_model("pre_rst");
    #2 rst_n = 1'b0;                      // between edges
    #1;
    chk("arst_lock", int'(chk_lock), 0);
    chk("arst_err",  int'(chk_err),  0);
    chk("arst_exp",  int'(exp_data), 0);
    chk("arst_ecnt", int'(err_cnt),  0);
`ifdef DATA_SEQ_CHK_STAT_EN
    chk("arst_rx",   int'(rx_cnt),   0);
`endif
    model_reset();
    @(posedge clk_b); #3 rst_n = 1'b1;
    @(posedge clk_b); #1;
    step(1, 6, 0);                        // re-enters via first-word path
    chk("post_rst_lock", int'(chk_lock), 0);
    chk("post_rst_exp",  int'(exp_data), 7);
    step(1, 7, 0);
    chk("post_rst_lock2", int'(chk_lock), 1);
    chk("post_rst_exp2",  int'(exp_data), 0);

    // ---------------- randomized run vs. model ----------------
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(9) < 8);
      c = ($urandom_range(39) == 0);
      d = ($urandom_range(9) < 7) ? m_exp : int'($urandom_range(15));
      step(v, d, c);
      check_model($sformatf("r%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_seq_checker.md
DATA_SEQ_CHECKER -- requirements
Module: data_seq_checker

Interface
REQ-001 SHALL have parameter DW, default 4, the data word width in bits.
REQ-002 SHALL have parameter WRAP, default 8: the sequence runs 0..WRAP-1, then wraps to 0; WRAP <= 2**DW.
REQ-003 SHALL have parameter LOCK_N, default 2: consecutive matching words required to declare lock.
REQ-004 SHALL have parameter ERR_MAX, default 3: consecutive mismatches in lock before lock is dropped.
REQ-005 SHALL have port clk_b, input, 1, the single clock; all logic is in the clk_b domain.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_vld, input, 1: data is valid this cycle; may be high on any cycle, including back-to-back cycles.
REQ-008 SHALL have port data, input, DW: the received word from the req/ack receiver stage.
REQ-009 SHALL have port sw_clr, input, 1: synchronous clear of the statistics counters.
REQ-010 SHALL have port chk_lock, output, 1: high while the FSM is in LOCK.
REQ-011 SHALL have port chk_err, output, 1: a one-cycle pulse on each mismatch detected in LOCK.
REQ-012 SHALL have port exp_data, output, DW: the next expected word.
REQ-013 SHALL have port err_cnt, output, 8: the total mismatches seen in LOCK; saturates at 255.
REQ-014 SHALL have port rx_cnt, output, 16: the number of accepted words; wraps from 65535 to 0. This port is present only with the macro in REQ-030.

Function
REQ-015 SHALL use a three-state FSM: IDLE, SYNC, LOCK.
REQ-016 SHALL define a word as "matching" when data_vld=1 and data==exp_data; any data >= WRAP is always a mismatch.
REQ-017 SHALL define re-anchoring: exp_data <= (data+1) mod WRAP if data < WRAP, else exp_data <= 0.
REQ-018 SHALL, in IDLE, on data_vld: re-anchor, set good_cnt=1, and go to SYNC; SHALL go directly to LOCK if LOCK_N==1.
REQ-019 SHALL, in SYNC, on a match: increment exp_data mod WRAP and good_cnt; SHALL go to LOCK when good_cnt reaches LOCK_N.
REQ-020 SHALL, in SYNC, on a mismatch: re-anchor, set good_cnt=1, stay in SYNC, and not assert chk_err.
REQ-021 SHALL, in LOCK, on a match: increment exp_data mod WRAP and clear bad_cnt.
REQ-022 SHALL, in LOCK, on a mismatch: pulse chk_err, increment err_cnt (saturating) and bad_cnt, and re-anchor.
REQ-023 SHALL, when bad_cnt reaches ERR_MAX: go to SYNC with good_cnt=1 and bad_cnt=0; chk_err still pulses for that word.
REQ-024 SHALL hold all state, exp_data, and counters when data_vld=0.
REQ-025 SHALL register all outputs: the response to a word sampled on edge N is visible after edge N (one-cycle latency).
REQ-026 SHALL implement wrap: exp_data goes from WRAP-1 to 0 on a match.
REQ-027 SHALL, on sw_clr=1: clear err_cnt and rx_cnt. A data_vld in the same cycle is still processed by the FSM and exp_data, but it is not counted; sw_clr SHALL NOT change the FSM state.

Reset
REQ-028 SHALL, on rst_n=0 (asynchronous, regardless of clk_b): state=IDLE, exp_data=0, chk_lock=0, chk_err=0, err_cnt=0, rx_cnt=0, good_cnt=0, bad_cnt=0.
REQ-029 SHALL, on reset asserted mid-sequence, discard any in-progress lock; the first word after release is handled as in IDLE.

Configuration
REQ-030 SHALL compile rx_cnt and its port only when macro DATA_SEQ_CHK_STAT_EN is defined; rx_cnt SHALL increment on every data_vld cycle without sw_clr.
REQ-031 SHALL, without DATA_SEQ_CHK_STAT_EN, omit the rx_cnt port and counter; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: reset, then data 0,1,2 with vld -> chk_lock=1 after the 2nd word, exp_data=3, err_cnt=0.
REQ-033 SHALL cover: locked, feed 5,6,7,0,1 -> no chk_err, and exp_data wraps 7->0 then reaches 2.
REQ-034 SHALL cover: locked at exp=3, feed 9 -> chk_err pulses for one cycle, err_cnt=1, exp_data=0, chk_lock stays 1.
REQ-035 SHALL cover: locked, three consecutive mismatches -> three chk_err pulses, err_cnt=3, chk_lock=0 after the 3rd, state SYNC.
REQ-036 SHALL cover: sw_clr together with a mismatching vld in LOCK -> err_cnt=0 next cycle, chk_err=1 for that cycle, and rx_cnt=0 (macro defined).
REQ-037 SHALL cover: rst_n pulsed low between clk_b edges while locked -> all outputs 0 immediately; the next word re-enters via IDLE.
